// File: rtl/popcount_frame_acc.sv
// Frame-level ones accumulator: popcounts each accepted word, sums FRAME_LEN words,
// then holds the total and its unsigned gt/eq/lt relation to a sampled threshold.
module Counting1s #(
  parameter int N = 8
) (
  input  logic [N-1:0]           data_i,
  output logic [$clog2(N+1)-1:0] count_o
);
  localparam int PW = $clog2(N+1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + {{(PW-1){1'b0}}, data_i[i]};
    end
  end
endmodule

module popcount_frame_acc #(
  parameter int N         = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [N-1:0]                       in_data,
  input  logic                               frame_abort,
  input  logic [$clog2(N*FRAME_LEN+1)-1:0]   thresh,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(N*FRAME_LEN+1)-1:0]   out_count,
  output logic                               out_gt,
  output logic                               out_eq,
  output logic                               out_lt
);
  localparam int AW = $clog2(N*FRAME_LEN+1);
  localparam int CW = $clog2(FRAME_LEN);
  localparam int PW = $clog2(N+1);
  localparam logic [CW-1:0] LAST_WORD = CW'(FRAME_LEN-1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [AW-1:0]   count_q, count_d;
  logic [2:0]      flags_q, flags_d;
  logic [PW-1:0]   pop;
  logic [AW-1:0]   sum;

  // Unsigned three-way compare packed as {gt, eq, lt}; exactly one bit is set.
  function automatic logic [2:0] compare(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return {a > b, a == b, a < b};
  endfunction

  Counting1s #(.N(N)) u_pop (
    .data_i  (in_data),
    .count_o (pop)
  );

  assign sum = acc_q + AW'(pop);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    wcnt_d  = wcnt_q;
    count_d = count_q;
    flags_d = flags_q;
    case (state_q)
      ACCUM: begin
        if (frame_abort) begin
          acc_d  = '0;
          wcnt_d = '0;
        end else if (in_valid) begin
          if (wcnt_q == LAST_WORD) begin
            count_d = sum;
            flags_d = compare(sum, thresh);
            acc_d   = '0;
            wcnt_d  = '0;
            state_d = HOLD;
          end else begin
            acc_d  = sum;
            wcnt_d = wcnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      wcnt_q  <= '0;
      count_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_count = count_q;
  assign out_gt    = flags_q[2];
  assign out_eq    = flags_q[1];
  assign out_lt    = flags_q[0];
endmodule

// File: tb/tb_popcount_frame_acc.sv
// Bench for popcount_frame_acc: directed scenarios plus random traffic, scoreboard-checked.
module tb_popcount_frame_acc;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       frame_abort = 1'b0;
  logic [5:0] thresh = 6'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_count;
  logic       out_gt, out_eq, out_lt;

  popcount_frame_acc #(.N(8), .FRAME_LEN(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .frame_abort (frame_abort),
    .thresh      (thresh),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_count   (out_count),
    .out_gt      (out_gt),
    .out_eq      (out_eq),
    .out_lt      (out_lt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cnt;
    logic [2:0] fl;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  int   frame_words[$];
  bit   m_hold = 1'b0;
  bit   seen = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a frame is the list of popcounts of the words it accepted.
  task automatic step(input bit v, input logic [7:0] d, input bit ab, input int th, input bit ordy);
    in_valid    = v;
    in_data     = d;
    frame_abort = ab;
    thresh      = th[5:0];
    out_ready   = ordy;
    @(posedge clk);
    if (m_hold) begin
      if (ordy) m_hold = 1'b0;
    end else if (ab) begin
      frame_words.delete();
    end else if (v) begin
      frame_words.push_back($countones(d));
      if (frame_words.size() == 4) begin
        int   t;
        exp_t e;
        t = 0;
        foreach (frame_words[i]) t += frame_words[i];
        e.cnt = t;
        e.fl  = {t > th, t == th, t < th};
        expq.push_back(e);
        frame_words.delete();
        m_hold = 1'b1;
      end
    end
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_count"}, int'(out_count), 0);
    chk({tag, "_flags"}, int'({out_gt, out_eq, out_lt}), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  // Monitor: pops one expected result per HOLD episode and checks it stays stable.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", int'(in_ready), m_hold ? 0 : 1);
      chk("out_valid", int'(out_valid), m_hold ? 1 : 0);
      if (out_valid) begin
        if (!seen) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%0d required=none at %0t", out_count, $time);
          end else begin
            cur  = expq.pop_front();
            seen = 1'b1;
          end
        end
        if (seen) begin
          chk("out_count", int'(out_count), cur.cnt);
          chk("flags", int'({out_gt, out_eq, out_lt}), int'(cur.fl));
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    #2;
    check_reset_state("por");
    #10 rst_n = 1'b1;

    // Basic frame, count 13 equals threshold
    step(1, 8'hFF, 0, 13, 1);
    step(1, 8'h0F, 0, 13, 1);
    step(1, 8'h01, 0, 13, 1);
    step(1, 8'h00, 0, 13, 1);
    step(0, 8'h00, 0, 13, 1);

    // Maximum total without wrap, then all-zero frame
    for (int i = 0; i < 4; i++) step(1, 8'hFF, 0, 31, 1);
    step(0, 8'h00, 0, 31, 1);
    for (int i = 0; i < 4; i++) step(1, 8'h00, 0, 1, 1);
    step(0, 8'h00, 0, 1, 1);

    // Backpressure with words offered during HOLD
    for (int i = 0; i < 4; i++) step(1, 8'h01, 0, 2, 0);
    for (int i = 0; i < 5; i++) step(1, 8'hFF, 0, 2, 0);
    step(1, 8'hFF, 0, 2, 1);
    for (int i = 0; i < 4; i++) step(1, 8'h02, 0, 4, 1);
    step(0, 8'h00, 0, 4, 1);

    // Abort drops the partial frame and the word presented with it
    step(1, 8'hFF, 0, 8, 1);
    step(1, 8'hFF, 0, 8, 1);
    step(1, 8'hFF, 1, 8, 1);
    for (int i = 0; i < 4; i++) step(1, 8'h03, 0, 8, 1);
    step(0, 8'h00, 0, 8, 1);

    // Asynchronous reset between clock edges, mid-frame
    step(1, 8'hFF, 0, 4, 1);
    step(1, 8'hFF, 0, 4, 1);
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    frame_words.delete();
    m_hold = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 8'h01, 0, 4, 1);
    step(0, 8'h00, 0, 4, 1);

    // Idle gaps between words; threshold changes during HOLD are ignored
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h07, 0, 12, 0);
      if (i < 3) for (int g = 0; g < 3; g++) step(0, 8'h00, 0, 12, 0);
    end
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
           $urandom_range(0, 15) == 0, int'($urandom_range(0, 32)),
           $urandom_range(0, 2) != 0);
    end

    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 1);
    chk("results_pending", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
